// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader and any future host-side stream model.
// Holds the FSM encoding and the reserved-bit masks of the LEN_HI / DAT_HI stream bytes.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_DAT_HI = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Bits of a high byte above a field of the given width must be zero in a well-formed stream.
  function automatic logic [7:0] hi_reserved_mask(input int unsigned width);
    return 8'hFF << (width - 32'd8);
  endfunction

  localparam logic [7:0] LEN_HI_RSVD_MASK = hi_reserved_mask(DEF_ADDR_W);
  localparam logic [7:0] DAT_HI_RSVD_MASK = hi_reserved_mask(DEF_DATA_W);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port of the loader.
// The slave modport is the loader side; master is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::DEF_ADDR_W,
  parameter int DATA_W = imem_loader_pkg::DEF_DATA_W
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader: packs byte pairs into instruction words, writes them
// from address 0 upward, then raises core_run once the last write has reached memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_run,
  output logic          err
);

  localparam logic [7:0] LEN_RSVD = hi_reserved_mask(ADDR_W);
  localparam logic [7:0] DAT_RSVD = hi_reserved_mask(DATA_W);

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        dat_lo_q, dat_lo_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              in_ready_q, in_ready_d;
  logic              core_run_q, core_run_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = in_ready_q && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      dat_lo_q    <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      core_run_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      dat_lo_q    <= dat_lo_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      in_ready_q  <= in_ready_d;
      core_run_q  <= core_run_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    dat_lo_d    = dat_lo_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.in_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if ((bus.in_data & LEN_RSVD) != 8'h00) begin
            state_d = S_ERR;
          end else if (ADDR_W'({bus.in_data, len_lo_q}) == '0) begin
            state_d = S_DONE;
          end else begin
            remaining_d = ADDR_W'({bus.in_data, len_lo_q});
            addr_d      = '0;
            state_d     = S_DAT_LO;
          end
        end
      end
      S_DAT_LO: begin
        if (accept) begin
          dat_lo_d = bus.in_data;
          state_d  = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (accept) begin
          if ((bus.in_data & DAT_RSVD) != 8'h00) begin
            state_d = S_ERR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = DATA_W'({bus.in_data, dat_lo_q});
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            state_d     = (remaining_q == ADDR_W'(1)) ? S_DONE : S_DAT_LO;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_LEN_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Holding core_run off while the final write is in flight delays it one cycle past mem_we.
    in_ready_d = state_d inside {S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI};
    core_run_d = (state_d == S_DONE) && !mem_we_d;
    err_d      = (state_d == S_ERR);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_run      = core_run_q;
  assign err           = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream instruction-memory loader for the Henad core. It is the write-side counterpart of the core's instruction fetch path. It accepts a length-prefixed byte stream over a valid/ready handshake and packs byte pairs into 12-bit instruction words. It writes those words sequentially into instruction memory from address 0, then raises `core_run` so the pipeline may begin fetching.

## Interface
Parameters:
- `ADDR_W`, 12: instruction memory address width; also the width of the length field.
- `DATA_W`, 12: instruction word width; must be 9..16 (`DATA_W-8` high bits are carried in the second byte).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins or restarts a load.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle; reset 0.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word; reset 0.
- `mem_addr`  out  ADDR_W  write address; reset 0.
- `mem_wdata`  out  DATA_W  write data; reset 0.
- `core_run`  out  1  load complete, core may run; reset 0.
- `err`  out  1  malformed stream detected; sticky; reset 0.

## Operation
- The stream carries `LEN_LO`, `LEN_HI`, then N pairs of (`DAT_LO`, `DAT_HI`), all low byte first.
  - `LEN_HI[7:ADDR_W-8]` and `DAT_HI[7:DATA_W-8]` must be zero.
  - N = {`LEN_HI[ADDR_W-9:0]`, `LEN_LO`}.
- A byte transfers on a rising edge with `in_valid && in_ready`.
- State machine: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, DONE, ERR.
  - IDLE: `in_ready`=0; `start` -> LEN_LO.
  - LEN_LO: accept byte into count low -> LEN_HI.
  - LEN_HI: accept byte. Nonzero reserved bits -> ERR. N=0 -> DONE with no writes. Otherwise -> DAT_LO, write address cleared to 0.
  - DAT_LO: accept byte into data low -> DAT_HI.
  - DAT_HI: accept byte. Nonzero reserved bits -> ERR, with no write for that word. Otherwise issue a write and decrement remaining. Remaining reaches 0 -> DONE, else -> DAT_LO.
  - DONE: `in_ready`=0, `core_run`=1.
  - ERR: `in_ready`=0, `err`=1, `core_run`=0.
- `start` in DONE or ERR -> LEN_LO, clearing `core_run`, `err` and the address counter.
- `start` is ignored in LEN_LO..DAT_HI.
- Address counter is ADDR_W bits and increments after each write.
- Maximum N = 2^ADDR_W-1, so the counter never wraps within one load.
- Bytes presented while `in_ready`=0 are not consumed. Upstream holds them.

## Timing
- `in_ready` is a registered function of state. It is 1 in LEN_LO/LEN_HI/DAT_LO/DAT_HI, independent of `in_valid`.
- `start` at edge k -> `in_ready`=1 from cycle k+1.
- Write latency: when DAT_HI is accepted at edge k, `mem_we`=1 with registered `mem_addr`/`mem_wdata` during cycle k+1, for exactly one cycle.
- `mem_addr` and `mem_wdata` hold their values between writes.
- Back-to-back bytes give one write every 2 cycles at full rate.
- Last word: its `mem_we` pulse occurs in cycle k+1, and `core_run` rises in cycle k+2. This guarantees memory is written before the core's first fetch.
- N=0: `core_run`=1 the cycle after LEN_HI is accepted.
- ERR: `err`=1 the cycle after the offending byte is accepted; `mem_we` stays 0.
- `rst_n` low at any time, including mid-load or during the `mem_we` cycle:
  - all outputs go to reset values immediately, and a pending write is dropped;
  - state returns to IDLE;
  - the partially written memory is not cleaned up.

## Structure
- State encodings and the stream field positions (`LEN_HI`/`DAT_HI` reserved-bit masks) go in a shared header alongside `src/iset.vh`, so a future loader-side host model uses the same constants.
- No sub-module: FSM, remaining counter, address counter and low-byte holding register sit in one module.
- Top-level integration:
  - `core_run` gates the core's stage1ia enable;
  - `mem_*` drive the write port added to `meminstr`.

## Test plan
- Reset release: `rst_n` 0->1, no `start`. Require all outputs 0 for 10 cycles.
- Stream 03,00, 34,02, 78,05, BC,0A at full rate. Require three writes, one every 2 cycles: (0,0x234), (1,0x578), (2,0xABC). `core_run`=1 two cycles after the last DAT_HI accept.
- Same stream with `in_valid` toggled randomly, and `start` pulsed mid-load. Require identical writes and no restart.
- Length 00,00. Require no `mem_we`, and `core_run`=1 one cycle after LEN_HI.
- Stream 02,00, 11,01, 22,F3. Require the first write (0,0x111), then no write, `err`=1, `in_ready`=0. A `start` then a valid single-word load clears `err` and writes address 0.
- `rst_n` asserted in the cycle `mem_we`=1 mid-stream. Require `mem_we`, `in_ready` and `core_run` at 0 immediately, and state IDLE after release.
